fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the 5-stage integer pipeline. It holds the program counter and drives the instruction-memory address. It presents the fetched word to the load-use stall detector and latches it into IF/ID for decode. It holds on the detector's `stall`, squashes on a taken branch or jump redirect, and inserts bubbles while instruction memory is not ready.

## Interface
Parameters:
- `RESET_PC`, default 32'h00000000: PC value loaded on reset. Bits [30:31] must be 0.
- `NOP_WORD`, default 32'h00000000: bubble encoding, an R-type op with rd = r0 and regWrite harmless.

Ports (bit order [0:N-1], MSB at index 0, as in the rest of the pipeline):
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `stall`, input, 1: load-use stall from the stall detector; hold PC and IF/ID.
- `redirect_en`, input, 1: taken branch or jump resolved downstream.
- `redirect_target`, input, [0:31]: new PC; bits [30:31] are ignored and forced to 0.
- `imem_data`, input, [0:31]: instruction word at `imem_addr`, combinational read.
- `imem_ready`, input, 1: `imem_data` is valid this cycle.
- `imem_addr`, output, [0:31]: current PC.
- `instr_if`, output, [0:31]: `imem_data` when `imem_ready`=1, else `NOP_WORD`; feeds the stall detector.
- `instr_id`, output, [0:31]: IF/ID instruction.
- `pc4_id`, output, [0:31]: IF/ID PC+4, used for link and branch-offset base.
- `valid_id`, output, 1: IF/ID holds a real instruction. It is 0 for a bubble.

## Operation
- Registers: `pc`, `instr_id`, `pc4_id`, `valid_id`.
- `pc_plus4` = `pc` + 4, modulo 2^32. 32'hFFFFFFFC wraps to 0.
- Next-state priority per cycle, highest first:
  1. `reset`: `pc`=RESET_PC, `instr_id`=NOP_WORD, `pc4_id`=0, `valid_id`=0.
  2. `redirect_en`: `pc` = {redirect_target[0:29],2'b00}; `instr_id`=NOP_WORD, `valid_id`=0, `pc4_id`=0. The current IF word is squashed, and so is the IF/ID word, even when `stall`=1 or `imem_ready`=0.
  3. `stall`: `pc` and all IF/ID registers hold unchanged, regardless of `imem_ready`.
  4. `imem_ready`=0: `pc` holds; IF/ID loads a bubble (`instr_id`=NOP_WORD, `valid_id`=0, `pc4_id`=0).
  5. Normal: `pc`=`pc_plus4`; `instr_id`=`imem_data`; `pc4_id`=`pc_plus4`; `valid_id`=1.
- Precedence: redirect over stall, because the stalled ID instruction is younger than the branch and dies anyway.
- `stall` is never asserted against a bubble by construction. If it is, the bubble is held; this is legal.
- `imem_addr` = `pc` combinationally. `instr_id`, `pc4_id` and `valid_id` are direct register outputs.

## Timing
- Reset values: `imem_addr`=RESET_PC, `instr_id`=NOP_WORD, `pc4_id`=0, `valid_id`=0.
- First fetch is at RESET_PC in the first cycle after `reset` deasserts. That word appears in IF/ID one cycle later.
- Fetch-to-decode latency: 1 cycle.
- Redirect: the target is on `imem_addr` in the cycle after `redirect_en`. It reaches IF/ID one cycle after that if `imem_ready`=1, giving a 1-bubble penalty.
- Stall: each asserted cycle freezes the pipe for exactly 1 cycle. There is no carry-over after deassertion.
- Reset mid-stall or mid-redirect: reset wins; the state is as after power-up.
- `stall` and `redirect_en` must be stable before the rising edge. There is no internal registering of either.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `stall_cnt` [0:31] and `bubble_cnt` [0:31], both reset to 0.
  - `stall_cnt` increments on each cycle where the stall branch (priority 3) is taken.
  - `bubble_cnt` increments on each cycle where priority 2 or 4 is taken.
  - Both saturate at 32'hFFFFFFFF and never wrap.
- `FETCH_PERF_CNT_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset release, `imem_ready`=1, sequential words A,B,C: `imem_addr` reads 0,4,8; one cycle later `instr_id` reads A,B,C with `pc4_id` 4,8,12 and `valid_id`=1.
- `stall`=1 for 2 cycles while B is in IF/ID and `pc`=8: `imem_addr` stays 8 and `instr_id` stays B for 2 cycles; then C is loaded.
- `redirect_en`=1 with target 32'h00000103 while `stall`=1: next `imem_addr`=32'h00000100, `valid_id`=0, `instr_id`=NOP_WORD.
- `imem_ready`=0 for 3 cycles at `pc`=12: `pc` holds at 12; `instr_if`=NOP_WORD; three bubbles with `valid_id`=0; the word is loaded on ready.
- PC wrap: redirect to 32'hFFFFFFFC then normal fetch: `pc4_id`=0 and next `imem_addr`=0.
- With `FETCH_PERF_CNT_EN`: 2 stall cycles, 1 redirect and 3 not-ready cycles give `stall_cnt`=2 and `bubble_cnt`=4. Reset mid-sequence gives both counters 0 and `pc`=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: stall/redirect controls, instruction-memory port and IF/ID outputs.
// The master modport is taken by fetch_stage; the slave modport by its surroundings.
interface fetch_stage_if;
  logic        stall;
  logic        redirect_en;
  logic [0:31] redirect_target;
  logic [0:31] imem_data;
  logic        imem_ready;
  logic [0:31] imem_addr;
  logic [0:31] instr_if;
  logic [0:31] instr_id;
  logic [0:31] pc4_id;
  logic        valid_id;

  modport master (
    input  stall, redirect_en, redirect_target, imem_data, imem_ready,
    output imem_addr, instr_if, instr_id, pc4_id, valid_id
  );

  modport slave (
    output stall, redirect_en, redirect_target, imem_data, imem_ready,
    input  imem_addr, instr_if, instr_id, pc4_id, valid_id
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC and IF/ID register; holds on stall, squashes on redirect.
// Optional performance counters (stall_cnt, bubble_cnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [0:31] RESET_PC = 32'h0000_0000,
  parameter logic [0:31] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  fetch_stage_if.master     bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [0:31]       stall_cnt,
  output logic [0:31]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    SEL_REDIRECT = 2'd0,
    SEL_STALL    = 2'd1,
    SEL_BUBBLE   = 2'd2,
    SEL_FETCH    = 2'd3
  } sel_e;

  sel_e        sel_s;
  logic [0:31] pc_r;
  logic [0:31] pc_plus4_s;
  logic [0:31] pc_next_s;
  logic [0:31] instr_id_r;
  logic [0:31] instr_id_next_s;
  logic [0:31] pc4_id_r;
  logic [0:31] pc4_id_next_s;
  logic        valid_id_r;
  logic        valid_id_next_s;

  assign pc_plus4_s    = pc_r + 32'd4;
  assign bus.imem_addr = pc_r;
  assign bus.instr_if  = bus.imem_ready ? bus.imem_data : NOP_WORD;
  assign bus.instr_id  = instr_id_r;
  assign bus.pc4_id    = pc4_id_r;
  assign bus.valid_id  = valid_id_r;

  // Priority select: redirect beats stall, stall beats a not-ready memory.
  always_comb begin
    sel_s = SEL_FETCH;
    if (bus.redirect_en) begin
      sel_s = SEL_REDIRECT;
    end else if (bus.stall) begin
      sel_s = SEL_STALL;
    end else if (!bus.imem_ready) begin
      sel_s = SEL_BUBBLE;
    end else begin
      sel_s = SEL_FETCH;
    end
  end

  // Next PC and IF/ID contents for the selected action.
  always_comb begin
    pc_next_s       = pc_r;
    instr_id_next_s = instr_id_r;
    pc4_id_next_s   = pc4_id_r;
    valid_id_next_s = valid_id_r;
    case (sel_s)
      SEL_REDIRECT: begin
        pc_next_s       = bus.redirect_target & 32'hFFFF_FFFC;
        instr_id_next_s = NOP_WORD;
        pc4_id_next_s   = 32'h0000_0000;
        valid_id_next_s = 1'b0;
      end
      SEL_STALL: begin
        pc_next_s       = pc_r;
        instr_id_next_s = instr_id_r;
        pc4_id_next_s   = pc4_id_r;
        valid_id_next_s = valid_id_r;
      end
      SEL_BUBBLE: begin
        pc_next_s       = pc_r;
        instr_id_next_s = NOP_WORD;
        pc4_id_next_s   = 32'h0000_0000;
        valid_id_next_s = 1'b0;
      end
      SEL_FETCH: begin
        pc_next_s       = pc_plus4_s;
        instr_id_next_s = bus.imem_data;
        pc4_id_next_s   = pc_plus4_s;
        valid_id_next_s = 1'b1;
      end
      default: begin
        pc_next_s       = pc_r;
        instr_id_next_s = NOP_WORD;
        pc4_id_next_s   = 32'h0000_0000;
        valid_id_next_s = 1'b0;
      end
    endcase
  end

  // PC and IF/ID register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      instr_id_r <= NOP_WORD;
      pc4_id_r   <= 32'h0000_0000;
      valid_id_r <= 1'b0;
    end else begin
      pc_r       <= pc_next_s;
      instr_id_r <= instr_id_next_s;
      pc4_id_r   <= pc4_id_next_s;
      valid_id_r <= valid_id_next_s;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [0:31] stall_cnt_r;
  logic [0:31] bubble_cnt_r;
  logic        bubble_inc_s;

  assign bubble_inc_s = (sel_s == SEL_REDIRECT) || (sel_s == SEL_BUBBLE);
  assign stall_cnt    = stall_cnt_r;
  assign bubble_cnt   = bubble_cnt_r;

  // Saturating event counters; they stop at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r  <= 32'h0000_0000;
      bubble_cnt_r <= 32'h0000_0000;
    end else begin
      if ((sel_s == SEL_STALL) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (bubble_inc_s && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps from the test plan, then
// randomized control inputs compared against a cycle-level reference model.
module tb_fetch_stage;
  localparam logic [0:31] RESET_PC = 32'h0000_0000;
  localparam logic [0:31] NOP_WORD = 32'h0000_0020;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [0:31] stall_cnt;
  logic [0:31] bubble_cnt;
  logic [0:31] m_stall_cnt;
  logic [0:31] m_bubble_cnt;
`endif

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_WORD (NOP_WORD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  // Instruction memory content: a scrambled function of the address.
  function automatic logic [0:31] mem_word(input logic [0:31] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [0:31] m_pc;
  logic [0:31] m_instr;
  logic [0:31] m_pc4;
  logic        m_valid;
  logic        cur_rdy;

  task automatic check(input string tag, input logic [0:31] obs, input logic [0:31] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("imem_addr", bus.imem_addr, m_pc);
    check("instr_if", bus.instr_if, cur_rdy ? mem_word(m_pc) : NOP_WORD);
    check("instr_id", bus.instr_id, m_instr);
    check("pc4_id", bus.pc4_id, m_pc4);
    check("valid_id", {31'd0, bus.valid_id}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall_cnt);
    check("bubble_cnt", bubble_cnt, m_bubble_cnt);
`endif
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_instr = NOP_WORD;
    m_pc4   = 32'h0000_0000;
    m_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    m_stall_cnt  = 32'h0000_0000;
    m_bubble_cnt = 32'h0000_0000;
`endif
  endtask

  // One clock of the pipeline as described by the priority rules.
  task automatic model_update(input logic r, input logic st, input logic re,
                              input logic [0:31] tgt, input logic rdy);
    logic bubble;
    bubble = 1'b0;
    if (r) begin
      model_reset();
    end else if (re) begin
      m_pc    = {tgt[0:29], 2'b00};
      m_instr = NOP_WORD;
      m_pc4   = 32'h0000_0000;
      m_valid = 1'b0;
      bubble  = 1'b1;
    end else if (st) begin
`ifdef FETCH_PERF_CNT_EN
      if (m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 32'd1;
`endif
    end else if (!rdy) begin
      m_instr = NOP_WORD;
      m_pc4   = 32'h0000_0000;
      m_valid = 1'b0;
      bubble  = 1'b1;
    end else begin
      m_instr = mem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
`ifdef FETCH_PERF_CNT_EN
    if (bubble && (m_bubble_cnt != 32'hFFFF_FFFF)) m_bubble_cnt = m_bubble_cnt + 32'd1;
`else
    if (bubble) m_valid = 1'b0;
`endif
  endtask

  // Drive at the falling edge, check outputs, clock once, advance the model.
  task automatic step(input logic r, input logic st, input logic re,
                      input logic [0:31] tgt, input logic rdy);
    reset               = r;
    bus.stall           = st;
    bus.redirect_en     = re;
    bus.redirect_target = tgt;
    bus.imem_ready      = rdy;
    cur_rdy             = rdy;
    #1;
    check_all();
    @(posedge clk);
    model_update(r, st, re, tgt, rdy);
    @(negedge clk);
  endtask

  initial begin
    reset               = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect_en     = 1'b0;
    bus.redirect_target = 32'h0000_0000;
    bus.imem_ready      = 1'b1;
    cur_rdy             = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);

    check("reset_addr", bus.imem_addr, RESET_PC);
    check("reset_instr", bus.instr_id, NOP_WORD);
    check("reset_valid", {31'd0, bus.valid_id}, 32'd0);

    // Sequential fetch of A, B
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("seq_addr", bus.imem_addr, 32'h0000_0008);
    check("seq_pc4", bus.pc4_id, 32'h0000_0008);

    // Two stall cycles with B in IF/ID
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("stall_addr", bus.imem_addr, 32'h0000_0008);
    check("stall_instr", bus.instr_id, mem_word(32'h0000_0004));
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("after_stall_instr", bus.instr_id, mem_word(32'h0000_0008));

    // Redirect wins over stall; low target bits dropped
    step(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b1);
    check("redir_addr", bus.imem_addr, 32'h0000_0100);
    check("redir_instr", bus.instr_id, NOP_WORD);
    check("redir_valid", {31'd0, bus.valid_id}, 32'd0);

    // Three not-ready cycles, then the word loads
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("nrdy_addr", bus.imem_addr, 32'h0000_0100);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("nrdy_load", bus.instr_id, mem_word(32'h0000_0100));
`ifdef FETCH_PERF_CNT_EN
    check("plan_stall_cnt", stall_cnt, 32'd2);
    check("plan_bubble_cnt", bubble_cnt, 32'd4);
`endif

    // PC wrap
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_pc4", bus.pc4_id, 32'h0000_0000);
    check("wrap_addr", bus.imem_addr, 32'h0000_0000);

    // Reset during a stall
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
    check("rst_mid_addr", bus.imem_addr, RESET_PC);
    check("rst_mid_valid", {31'd0, bus.valid_id}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_mid_stall_cnt", stall_cnt, 32'd0);
    check("rst_mid_bubble_cnt", bubble_cnt, 32'd0);
`endif

    // Randomized control traffic
    for (int i = 0; i < 400; i++) begin
      logic        r_r, st_r, re_r, rdy_r;
      logic [0:31] tgt_r;
      r_r   = ($urandom_range(0, 99) < 2);
      st_r  = ($urandom_range(0, 99) < 15);
      re_r  = ($urandom_range(0, 99) < 10);
      rdy_r = ($urandom_range(0, 99) < 80);
      tgt_r = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step(r_r, st_r, re_r, tgt_r, rdy_r);
    end

    bus.imem_ready = 1'b1;
    cur_rdy        = 1'b1;
    #1;
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
